// File: rtl/spi_tx_multimode.sv
`default_nettype none
// ============================================================================
//  Module   : spi_tx_multimode
//  Purpose  : SPI master transmitter. Sends one DATA_W-bit word per accepted
//             request to one of NUM_CS slaves. Supports all four CPOL/CPHA
//             modes, MSB- or LSB-first order, a programmable SCLK half-period
//             (CLK_DIV) and programmable CS setup/hold times.
//             Sequence: IDLE -> PARK -> SETUP -> SHIFT -> HOLD -> IDLE.
//  Optional : define SPI_TX_MISO_CAPTURE_EN to add MISO capture
//             (i_MISO, o_RxData, o_RxValid). Capture needs CLK_DIV >= 3
//             because of the 2-flop MISO synchroniser.
//  Ports    : i_Clk, i_Rst (async, active-high)
//             i_Valid/o_Ready  request handshake, accept = i_Valid && o_Ready
//             i_Data, i_CsSel, i_CPOL, i_CPHA, i_MsbFirst  latched on accept
//             o_SCLK, o_MOSI, o_CS_L[NUM_CS] (active-low)  SPI bus, registered
//             [opt] i_MISO, o_RxData, o_RxValid (1-cycle pulse in first HOLD cycle)
//  Revision : 1.0  initial multi-mode, multi-CS release
// ============================================================================
module spi_tx_multimode #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int NUM_CS   = 1,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  localparam int CSW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Valid,
  input  logic [DATA_W-1:0] i_Data,
  input  logic [CSW-1:0]    i_CsSel,
  input  logic              i_CPOL,
  input  logic              i_CPHA,
  input  logic              i_MsbFirst,
  output logic              o_Ready,
  output logic              o_SCLK,
  output logic              o_MOSI,
  output logic [NUM_CS-1:0] o_CS_L
`ifdef SPI_TX_MISO_CAPTURE_EN
  ,
  input  logic              i_MISO,
  output logic [DATA_W-1:0] o_RxData,
  output logic              o_RxValid
`endif
);

  localparam int HALF_W    = $clog2(CLK_DIV + 1);
  localparam int EDGE_W    = $clog2(2 * DATA_W + 1);
  localparam int PHASE_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

  localparam logic [EDGE_W-1:0]  LAST_EDGE    = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0]  PENULT_EDGE  = EDGE_W'(2 * DATA_W - 1);
  localparam logic [HALF_W-1:0]  HALF_RELOAD  = HALF_W'(CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] SETUP_RELOAD = PHASE_W'(CS_SETUP - 1);
  localparam logic [PHASE_W-1:0] HOLD_RELOAD  = PHASE_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PARK  = 3'd1,
    S_SETUP = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t              state, next_state;
  logic [DATA_W-1:0]   data_sr;
  logic [CSW-1:0]      cs_sel_r;
  logic                cpol_r, cpha_r, msb_r;
  logic [PHASE_W-1:0]  phase_cnt;
  logic [HALF_W-1:0]   half_cnt;
  logic [EDGE_W-1:0]   edge_cnt;   // number of SCLK edges already produced

  logic                phase_done, half_done, last_edge;
  logic                edge_fire, present;
  logic [NUM_CS-1:0]   cs_mask;
  logic                next_bit;
  logic [DATA_W-1:0]   shifted;

  assign phase_done = (phase_cnt == '0);
  assign half_done  = (half_cnt == '0);
  assign last_edge  = (edge_cnt == LAST_EDGE);

  // An SCLK edge is produced on leaving SETUP (edge 1) and at the end of
  // every SHIFT half-period except the last one.
  assign edge_fire = ((state == S_SETUP) && phase_done) ||
                     ((state == S_SHIFT) && half_done && !last_edge);

  // Edge number about to fire is edge_cnt+1, so edge_cnt even means an odd
  // (leading) edge. CPHA=0 drives bit 0 while still in PARK (visible through
  // SETUP) and further bits on even edges, except the final even edge.
  assign present = ((state == S_PARK) && !cpha_r) ||
                   (edge_fire && (cpha_r ? !edge_cnt[0]
                                         : (edge_cnt[0] && (edge_cnt != PENULT_EDGE))));

  assign next_bit = msb_r ? data_sr[DATA_W-1] : data_sr[0];
  assign shifted  = msb_r ? {data_sr[DATA_W-2:0], 1'b0} : {1'b0, data_sr[DATA_W-1:1]};

  // Out-of-range selects match no slave: the transfer runs with all CS high.
  always_comb begin
    cs_mask = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel_r == CSW'(i)) cs_mask[i] = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (i_Valid) next_state = S_PARK;
      S_PARK:  next_state = S_SETUP;
      S_SETUP: if (phase_done) next_state = S_SHIFT;
      S_SHIFT: if (half_done && last_edge) next_state = S_HOLD;
      S_HOLD:  if (phase_done) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Ready   <= 1'b1;
      o_SCLK    <= 1'b0;
      o_MOSI    <= 1'b0;
      o_CS_L    <= '1;
      cpol_r    <= 1'b0;
      cpha_r    <= 1'b0;
      msb_r     <= 1'b0;
      cs_sel_r  <= '0;
      data_sr   <= '0;
      phase_cnt <= '0;
      half_cnt  <= '0;
      edge_cnt  <= '0;
    end else begin
      o_Ready <= (next_state == S_IDLE);
      case (state)
        S_IDLE: begin
          if (i_Valid) begin
            data_sr  <= i_Data;
            cs_sel_r <= i_CsSel;
            cpol_r   <= i_CPOL;
            cpha_r   <= i_CPHA;
            msb_r    <= i_MsbFirst;
            // New idle level is applied in PARK while CS is still high.
            o_SCLK   <= i_CPOL;
          end
        end
        S_PARK: begin
          o_CS_L    <= cs_mask;
          phase_cnt <= SETUP_RELOAD;
          edge_cnt  <= '0;
        end
        S_SETUP: begin
          if (phase_done) begin
            o_SCLK   <= ~o_SCLK;
            edge_cnt <= edge_cnt + 1'b1;
            half_cnt <= HALF_RELOAD;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        S_SHIFT: begin
          if (half_done) begin
            if (last_edge) begin
              phase_cnt <= HOLD_RELOAD;
            end else begin
              o_SCLK   <= ~o_SCLK;
              edge_cnt <= edge_cnt + 1'b1;
              half_cnt <= HALF_RELOAD;
            end
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (phase_done) o_CS_L <= '1;
          else            phase_cnt <= phase_cnt - 1'b1;
        end
        default: o_CS_L <= '1;
      endcase

      if (present) begin
        o_MOSI  <= next_bit;
        data_sr <= shifted;
      end
    end
  end

`ifdef SPI_TX_MISO_CAPTURE_EN
  logic              miso_meta, miso_sync;
  logic [DATA_W-1:0] rx_sr;
  logic              sample;

  // Sampling edges: odd edges for CPHA=0, even edges for CPHA=1.
  assign sample = edge_fire && (cpha_r ? edge_cnt[0] : !edge_cnt[0]);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
      rx_sr     <= '0;
      o_RxData  <= '0;
      o_RxValid <= 1'b0;
    end else begin
      miso_meta <= i_MISO;
      miso_sync <= miso_meta;
      if (sample) begin
        if (msb_r) rx_sr <= {rx_sr[DATA_W-2:0], miso_sync};
        else       rx_sr <= {miso_sync, rx_sr[DATA_W-1:1]};
      end
      o_RxValid <= 1'b0;
      if ((state == S_SHIFT) && (next_state == S_HOLD)) begin
        o_RxData  <= rx_sr;
        o_RxValid <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
